// File: rtl/oc_vote_checker.sv
// Result checker for three open-collector gate implementations: waits for a
// stable input vector, majority-votes y0/y1 and flags dissenting implementations.
module oc_vote_checker #(
  parameter int unsigned SETTLE = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [2:0]       abc,
  input  logic [2:0]       y0,
  input  logic [2:0]       y1,
  output logic             chk_valid,
  output logic             vote_y0,
  output logic             vote_y1,
  output logic [2:0]       fail,
  output logic [CNT_W-1:0] chk_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CHECK, ST_HOLD} state_t;

  localparam logic [7:0] CNT_INIT = 8'(SETTLE - 1);

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  state_t           state_q, state_d;
  logic [2:0]       abc_q, abc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             vote_y0_q, vote_y0_d;
  logic             vote_y1_q, vote_y1_d;
  logic [2:0]       fail_q, fail_d;
  logic [CNT_W-1:0] chk_cnt_q, chk_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             chk_valid_q, chk_valid_d;
  logic             busy_q, busy_d;

  logic             change;
  logic             capture;
  logic             sample;
  logic             maj_y0;
  logic             maj_y1;
  logic [2:0]       fail_now;

  always_comb begin
    change   = (abc != abc_q);
    maj_y0   = maj3(y0);
    maj_y1   = maj3(y1);
    fail_now = (y0 ^ {3{maj_y0}}) | (y1 ^ {3{maj_y1}});
    capture  = 1'b0;
    sample   = 1'b0;

    state_d   = state_q;
    abc_d     = abc_q;
    cnt_d     = cnt_q;
    vote_y0_d = vote_y0_q;
    vote_y1_d = vote_y1_q;
    fail_d    = fail_q;
    chk_cnt_d = chk_cnt_q;
    err_cnt_d = err_cnt_q;

    if (!en) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:   capture = 1'b1;
        ST_SETTLE: begin
          if (change)             capture = 1'b1;
          else if (cnt_q != 8'd0) cnt_d   = cnt_q - 8'd1;
          else                    sample  = 1'b1;
        end
        ST_CHECK:  begin
          if (change) capture = 1'b1;
          else        state_d = ST_HOLD;
        end
        ST_HOLD:   capture = change;
        default:   state_d = ST_IDLE;
      endcase
    end

    if (capture) begin
      abc_d   = abc;
      cnt_d   = CNT_INIT;
      state_d = ST_SETTLE;
    end

    if (sample) begin
      state_d   = ST_CHECK;
      vote_y0_d = maj_y0;
      vote_y1_d = maj_y1;
      fail_d    = fail_now;
      if (chk_cnt_q != '1)                  chk_cnt_d = chk_cnt_q + CNT_W'(1);
      if ((fail_now != 3'b000) && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_W'(1);
    end

    // Clear wins over a same-edge increment.
    if (clr) begin
      chk_cnt_d = '0;
      err_cnt_d = '0;
    end

    chk_valid_d = (state_d == ST_CHECK);
    busy_d      = (state_d == ST_SETTLE) || (state_d == ST_CHECK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      abc_q       <= '0;
      cnt_q       <= '0;
      vote_y0_q   <= 1'b0;
      vote_y1_q   <= 1'b0;
      fail_q      <= '0;
      chk_cnt_q   <= '0;
      err_cnt_q   <= '0;
      chk_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      abc_q       <= abc_d;
      cnt_q       <= cnt_d;
      vote_y0_q   <= vote_y0_d;
      vote_y1_q   <= vote_y1_d;
      fail_q      <= fail_d;
      chk_cnt_q   <= chk_cnt_d;
      err_cnt_q   <= err_cnt_d;
      chk_valid_q <= chk_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign chk_valid = chk_valid_q;
  assign vote_y0   = vote_y0_q;
  assign vote_y1   = vote_y1_q;
  assign fail      = fail_q;
  assign chk_cnt   = chk_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_oc_vote_checker.sv
// Directed bench for oc_vote_checker: default, 2-bit counter and SETTLE=1
// instances share one stimulus stream.
module tb_oc_vote_checker;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       clr;
  logic [2:0] abc;
  logic [2:0] y0;
  logic [2:0] y1;

  logic       d_valid, d_vy0, d_vy1, d_busy;
  logic [2:0] d_fail;
  logic [7:0] d_chk, d_err;

  logic       s_valid, s_vy0, s_vy1, s_busy;
  logic [2:0] s_fail;
  logic [1:0] s_chk, s_err;

  logic       o_valid, o_vy0, o_vy1, o_busy;
  logic [2:0] o_fail;
  logic [7:0] o_chk, o_err;

  int unsigned n_checks;
  int unsigned n_fail;

  oc_vote_checker #(.SETTLE(4), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .abc(abc), .y0(y0), .y1(y1),
    .chk_valid(d_valid), .vote_y0(d_vy0), .vote_y1(d_vy1), .fail(d_fail),
    .chk_cnt(d_chk), .err_cnt(d_err), .busy(d_busy)
  );

  oc_vote_checker #(.SETTLE(4), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .abc(abc), .y0(y0), .y1(y1),
    .chk_valid(s_valid), .vote_y0(s_vy0), .vote_y1(s_vy1), .fail(s_fail),
    .chk_cnt(s_chk), .err_cnt(s_err), .busy(s_busy)
  );

  oc_vote_checker #(.SETTLE(1), .CNT_W(8)) u_s1 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .abc(abc), .y0(y0), .y1(y1),
    .chk_valid(o_valid), .vote_y0(o_vy0), .vote_y1(o_vy1), .fail(o_fail),
    .chk_cnt(o_chk), .err_cnt(o_err), .busy(o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Edges until u_dut pulses chk_valid (inclusive); 99 if none within budget.
  task automatic wait_pulse(output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (!d_valid && n < 20);
    if (!d_valid) n = 99;
  endtask

  int  n;
  logic saw;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    en    = 1'($urandom);
    clr   = 1'($urandom);
    abc   = 3'($urandom);
    y0    = 3'($urandom);
    y1    = 3'($urandom);
    #12;
    check("rst_outputs", {d_valid, d_vy0, d_vy1, d_fail, d_busy}, 32'h0);
    check("rst_counts", {d_chk, d_err}, 32'h0);

    en = 1'b0; clr = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(3);
    check("idle_en0", {d_valid, d_busy}, 32'h0);

    // Agreement
    en = 1'b1; abc = 3'b001; y0 = 3'b111; y1 = 3'b000;
    step(1);
    check("agree_e0", {d_busy, d_valid}, 32'h2);
    step(1);
    check("s1_pulse_e1", o_valid, 32'h1);
    check("agree_e1", d_valid, 32'h0);
    step(2);
    check("agree_e3", d_valid, 32'h0);
    step(1);
    check("agree_e4_valid", d_valid, 32'h1);
    check("agree_votes", {d_vy0, d_vy1, d_fail}, {27'h0, 5'b10000});
    check("agree_counts", {d_chk, d_err}, {16'h0, 8'd1, 8'd0});
    step(1);
    check("agree_hold", {d_valid, d_busy}, 32'h0);

    // Single disagreement: implementation 3 dissents on both outputs
    abc = 3'b010; y0 = 3'b011; y1 = 3'b100;
    wait_pulse(n);
    check("dis_latency", n, 5);
    check("dis_votes", {d_vy0, d_vy1, d_fail}, {27'h0, 5'b10100});
    check("dis_counts", {d_chk, d_err}, {16'h0, 8'd2, 8'd1});

    // Window restart two edges in
    abc = 3'b001; y0 = 3'b111; y1 = 3'b000;
    step(2);
    abc = 3'b011;
    wait_pulse(n);
    check("restart_latency", n, 5);
    check("restart_counts", {d_chk, d_err, d_fail}, {13'h0, 8'd3, 8'd1, 3'b000});

    // Change during CHECK restarts the window on that same edge
    abc = 3'b100;
    wait_pulse(n);
    check("chkchange_latency", n, 5);
    check("chkchange_cnt", d_chk, 4);

    // en dropped mid-window
    step(1);
    abc = 3'b101;
    step(2);
    en = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      saw |= d_valid;
    end
    check("abort_en_nopulse", saw, 0);
    check("abort_en_state", {d_busy, d_chk, d_err}, {15'h0, 8'd4, 8'd1});

    // IDLE recaptures even though abc equals abc_q
    en = 1'b1;
    wait_pulse(n);
    check("reen_latency", n, 5);
    check("reen_cnt", d_chk, 5);

    // Reset mid-window
    step(1);
    abc = 3'b110;
    step(2);
    rst_n = 1'b0;
    #1;
    check("rstmid_outputs", {d_valid, d_busy, d_vy0, d_vy1, d_fail, d_chk, d_err}, 32'h0);
    step(2);
    rst_n = 1'b1;
    wait_pulse(n);
    check("rstmid_latency", n, 5);
    check("rstmid_cnt", {d_chk, d_err}, {16'h0, 8'd1, 8'd0});

    // Saturation at CNT_W=2
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("clr_sat", {s_chk, s_err}, 32'h0);
    y0 = 3'b011; y1 = 3'b000;
    for (int i = 0; i < 5; i++) begin
      abc = 3'(i);
      wait_pulse(n);
      check("sat_latency", n, 5);
    end
    check("sat_counts", {s_chk, s_err}, {28'h0, 2'd3, 2'd3});
    check("sat_fail", s_fail, 3'b100);
    check("dut_counts_5", {d_chk, d_err}, {16'h0, 8'd5, 8'd5});

    // Clear on the same edge as an increment
    abc = 3'b101;
    step(4);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("clr_edge_valid", d_valid, 1);
    check("clr_edge_sat", {s_chk, s_err}, 32'h0);
    check("clr_edge_dut", {d_chk, d_err}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
